// File: rtl/control_unit_if.sv
// Bundle between the multicycle controller and the datapath: instruction
// fields and Zero flag in, every datapath select and enable out.
interface control_unit_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;

  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       WE3;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUControl;
  logic [1:0] immSrc;
  logic [3:0] state;
  logic       illegal;

  modport master (
    input  op, funct3, funct7b5, Zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, WE3,
           ResultSrc, ALUSrcA, ALUSrcB, ALUControl, immSrc, state, illegal
  );

  modport slave (
    output op, funct3, funct7b5, Zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, WE3,
           ResultSrc, ALUSrcA, ALUSrcB, ALUControl, immSrc, state, illegal
  );
endinterface

// File: rtl/control_unit.sv
// Multicycle RISC-V main controller (Moore FSM) plus ALU decoder.
// Define CONTROL_UNIT_ILLEGAL_TRAP_EN to trap unknown opcodes in ERROR.
module control_unit (
  input  logic           clk,
  input  logic           reset,
  control_unit_if.master bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    ERROR    = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  state_t     cur_state, next_state;
  alu_op_t    alu_op;
  logic       pc_update, branch, ir_write, we3, mem_write, adr_src;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_control;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cur_state <= FETCH;
    else        cur_state <= next_state;
  end

  always_comb begin
    next_state = FETCH;
    alu_op     = ALU_ADD;
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_write   = 1'b0;
    we3        = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    case (cur_state)
      FETCH: begin
        ir_write   = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_update  = 1'b1;
        next_state = DECODE;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (bus.op)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_R:         next_state = EXECUTER;
          OP_I:         next_state = EXECUTEI;
          OP_JAL:       next_state = JAL;
          OP_BEQ:       next_state = BEQ;
`ifdef CONTROL_UNIT_ILLEGAL_TRAP_EN
          default:      next_state = ERROR;
`else
          default:      next_state = FETCH;
`endif
        endcase
      end
      MEMADR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        next_state = (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        adr_src    = 1'b1;
        next_state = MEMWB;
      end
      MEMWB: begin
        result_src = 2'b01;
        we3        = 1'b1;
      end
      MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      EXECUTER: begin
        alu_src_a  = 2'b10;
        alu_op     = ALU_FUNCT;
        next_state = ALUWB;
      end
      EXECUTEI: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        alu_op     = ALU_FUNCT;
        next_state = ALUWB;
      end
      ALUWB: we3 = 1'b1;
      JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        pc_update  = 1'b1;
        next_state = ALUWB;
      end
      BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = ALU_SUB;
        branch    = 1'b1;
      end
`ifdef CONTROL_UNIT_ILLEGAL_TRAP_EN
      ERROR: next_state = ERROR;
`endif
      default: next_state = FETCH;
    endcase
  end

  // op[5] separates R-type from I-type, so addi never turns into a subtract
  always_comb begin
    alu_control = 2'b00;
    case (alu_op)
      ALU_SUB: alu_control = 2'b01;
      ALU_FUNCT: begin
        case (bus.funct3)
          3'b000:  alu_control = (bus.funct7b5 && bus.op[5]) ? 2'b01 : 2'b00;
          3'b111:  alu_control = 2'b10;
          3'b110:  alu_control = 2'b11;
          default: alu_control = 2'b00;
        endcase
      end
      default: alu_control = 2'b00;
    endcase
  end

  always_comb begin
    case (bus.op)
      OP_SW:   bus.immSrc = 2'b01;
      OP_BEQ:  bus.immSrc = 2'b10;
      OP_JAL:  bus.immSrc = 2'b11;
      default: bus.immSrc = 2'b00;
    endcase
  end

  // Enables are gated by reset so they drop the moment reset asserts
  assign bus.PCWrite    = reset & (pc_update | (branch & bus.Zero));
  assign bus.IRWrite    = reset & ir_write;
  assign bus.WE3        = reset & we3;
  assign bus.MemWrite   = reset & mem_write;
  assign bus.AdrSrc     = adr_src;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ALUControl = alu_control;
  assign bus.state      = cur_state;

`ifdef CONTROL_UNIT_ILLEGAL_TRAP_EN
  assign bus.illegal = (cur_state == ERROR);
`else
  assign bus.illegal = 1'b0;
`endif

endmodule
